// File: rtl/mult_digit_serial.sv
// Iterative digit-serial unsigned multiplier: one DIGIT x DIGIT partial product per
// cycle, shifted by DIGIT*(i+j) and summed into a 2*WIDTH accumulator.
module mult_digit_serial #(
    parameter int WIDTH     = 4,
    parameter int DIGIT     = 2,
    parameter int SKIP_ZERO = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int N     = WIDTH / DIGIT;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int SH_W  = $clog2(2 * WIDTH) + 1;

    if ((WIDTH % DIGIT) != 0 || WIDTH < DIGIT) begin : g_param_check
        $error("mult_digit_serial: WIDTH (%0d) must be a non-zero multiple of DIGIT (%0d)",
               WIDTH, DIGIT);
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_p;
    logic [IDX_W-1:0]     r_i;
    logic [IDX_W-1:0]     r_j;

    logic [SH_W-1:0]      w_sh_a;
    logic [SH_W-1:0]      w_sh_b;
    logic [SH_W-1:0]      w_sh_pp;
    logic [DIGIT-1:0]     w_digit_a;
    logic [DIGIT-1:0]     w_digit_b;
    logic [2*DIGIT-1:0]   w_prod;
    logic [2*WIDTH-1:0]   w_pp;
    logic [2*WIDTH-1:0]   w_acc_sum;
    logic                 w_last_i;
    logic                 w_last_j;
    logic                 w_skip;

    // Digit selection by shifting keeps every index width explicit.
    assign w_sh_a    = SH_W'(DIGIT) * SH_W'(r_i);
    assign w_sh_b    = SH_W'(DIGIT) * SH_W'(r_j);
    assign w_sh_pp   = w_sh_a + w_sh_b;
    assign w_digit_a = DIGIT'(r_a >> w_sh_a);
    assign w_digit_b = DIGIT'(r_b >> w_sh_b);
    assign w_prod    = (2*DIGIT)'(w_digit_a) * (2*DIGIT)'(w_digit_b);
    assign w_pp      = (2*WIDTH)'(w_prod) << w_sh_pp;
    assign w_acc_sum = r_acc + w_pp;

    assign w_last_i  = (r_i == IDX_W'(N - 1));
    assign w_last_j  = (r_j == IDX_W'(N - 1));
    assign w_skip    = (SKIP_ZERO != 0) && (r_j == '0) && (w_digit_a == '0);

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign p         = r_p;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the default assignment first means every path drives w_state_nxt, so no latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nxt = S_CALC;
            S_CALC:  if (w_last_i && (w_skip || w_last_j)) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_p   <= '0;
            r_i   <= '0;
            r_j   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_acc <= '0;
                        r_i   <= '0;
                        r_j   <= '0;
                    end
                end
                S_CALC: begin
                    if (w_skip) begin
                        r_i <= r_i + IDX_W'(1);
                        r_j <= '0;
                        if (w_last_i) r_p <= r_acc;
                    end else begin
                        r_acc <= w_acc_sum;
                        if (w_last_j) begin
                            r_j <= '0;
                            r_i <= r_i + IDX_W'(1);
                            if (w_last_i) r_p <= w_acc_sum;
                        end else begin
                            r_j <= r_j + IDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_digit_serial.sv
// Directed bench for mult_digit_serial: three parameter sets, scoreboard of expected
// products/latencies pushed at stimulus time and popped when out_valid appears.
module tb_mult_digit_serial;

    typedef struct {
        logic [15:0] p;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [7:0]  a_drv;
    logic [7:0]  b_drv;
    logic [2:0]  in_valid_v;
    logic [2:0]  out_ready_v;
    logic [2:0]  in_ready_v;
    logic [2:0]  out_valid_v;
    logic [2:0]  busy_v;
    logic [7:0]  p4;
    logic [15:0] p8;
    logic [15:0] p8s;
    logic [15:0] p_sel;

    int   sel;
    int   n_vec;
    int   n_err;
    exp_t exp_q[$];

    mult_digit_serial #(.WIDTH(4), .DIGIT(2), .SKIP_ZERO(0)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_drv[3:0]), .b(b_drv[3:0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .p(p4), .busy(busy_v[0])
    );

    mult_digit_serial #(.WIDTH(8), .DIGIT(2), .SKIP_ZERO(0)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_drv), .b(b_drv),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .p(p8), .busy(busy_v[1])
    );

    mult_digit_serial #(.WIDTH(8), .DIGIT(2), .SKIP_ZERO(1)) u_dut8s (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a_drv), .b(b_drv),
        .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
        .p(p8s), .busy(busy_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        p_sel = p8s;
        if (sel == 0)      p_sel = {8'h00, p4};
        else if (sel == 1) p_sel = p8;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference latency: N*N without skipping, otherwise N per nonzero A digit, 1 per zero digit.
    function automatic int model_lat(input int s, input logic [7:0] av);
        int n;
        int lat;
        n   = (s == 0) ? 2 : 4;
        lat = 0;
        if (s != 2) return n * n;
        for (int d = 0; d < n; d++) lat += (av[2*d +: 2] != 2'b00) ? n : 1;
        return lat;
    endfunction

    function automatic logic [15:0] model_p(input int s, input logic [7:0] av, input logic [7:0] bv);
        if (s == 0) return 16'(av[3:0]) * 16'(bv[3:0]);
        return 16'(av) * 16'(bv);
    endfunction

    task automatic push_exp(input logic [7:0] av, input logic [7:0] bv);
        exp_t e;
        e.p   = model_p(sel, av, bv);
        e.lat = model_lat(sel, av);
        exp_q.push_back(e);
    endtask

    // Called #1 after the acceptance edge; counts edges until out_valid, bounded.
    task automatic wait_result(input string tag);
        int   cyc;
        exp_t e;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!out_valid_v[sel] && cyc < 200);
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_lat"}, 32'(cyc), 32'(e.lat));
            check({tag, "_p"}, 32'(p_sel), 32'(e.p));
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready_v[sel]), 32'd1);
        a_drv = av;
        b_drv = bv;
        in_valid_v[sel] = 1'b1;
        push_exp(av, bv);
        @(posedge clk);
        #1;
        in_valid_v[sel] = 1'b0;
        a_drv = ~av;
        b_drv = ~bv;
        wait_result(tag);
        if (out_ready_v[sel]) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [7:0] b2b_a [4];
    logic [7:0] b2b_b [4];

    initial begin
        n_vec       = 0;
        n_err       = 0;
        sel         = 0;
        rst         = 1'b1;
        a_drv       = '0;
        b_drv       = '0;
        in_valid_v  = 3'b111;
        out_ready_v = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("rst_in_ready", 32'(in_ready_v[s]), 32'd1);
            check("rst_out_valid", 32'(out_valid_v[s]), 32'd0);
            check("rst_busy", 32'(busy_v[s]), 32'd0);
            check("rst_p", 32'(p_sel), 32'd0);
        end
        @(negedge clk);
        in_valid_v = 3'b000;
        rst = 1'b0;

        sel = 0;
        run_op("w4_ff", 8'h0F, 8'h0F);
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                run_op("w4_sweep", 8'(x), 8'(y));
            end
        end

        sel = 1;
        run_op("w8_ffff", 8'hFF, 8'hFF);
        run_op("w8_zero", 8'h00, 8'h9C);
        run_op("w8_mix", 8'hA7, 8'h3D);

        sel = 2;
        run_op("w8s_03", 8'h03, 8'hC5);
        run_op("w8s_zero", 8'h00, 8'hFF);
        run_op("w8s_40", 8'h40, 8'hB3);
        run_op("w8s_full", 8'hE6, 8'h5A);

        // Backpressure: result held, new operands ignored while DONE.
        sel = 0;
        out_ready_v[0] = 1'b0;
        run_op("bp_first", 8'h0C, 8'h0D);
        in_valid_v[0] = 1'b1;
        a_drv = 8'h02;
        b_drv = 8'h02;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("bp_p_hold", 32'(p_sel), 32'd156);
            check("bp_in_ready", 32'(in_ready_v[0]), 32'd0);
            check("bp_out_valid", 32'(out_valid_v[0]), 32'd1);
        end
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        out_ready_v[0] = 1'b1;
        @(posedge clk);
        #1;
        check("bp_in_ready_rise", 32'(in_ready_v[0]), 32'd1);
        run_op("bp_next", 8'h03, 8'h05);

        // Reset in the second CALC cycle aborts without presenting a result.
        @(negedge clk);
        a_drv = 8'h09;
        b_drv = 8'h07;
        in_valid_v[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_v[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", 32'(out_valid_v[0]), 32'd0);
        check("rst_mid_p", 32'(p_sel), 32'd0);
        check("rst_mid_busy", 32'(busy_v[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_in_ready", 32'(in_ready_v[0]), 32'd1);
        run_op("rst_after", 8'h06, 8'h0B);

        // Back-to-back: in_valid held high, each accept one cycle after the DONE handshake.
        b2b_a[0] = 8'h07; b2b_b[0] = 8'h09;
        b2b_a[1] = 8'h0F; b2b_b[1] = 8'h01;
        b2b_a[2] = 8'h00; b2b_b[2] = 8'h0D;
        b2b_a[3] = 8'h0A; b2b_b[3] = 8'h0A;
        @(negedge clk);
        a_drv = b2b_a[0];
        b_drv = b2b_b[0];
        in_valid_v[0] = 1'b1;
        for (int k = 0; k < 4; k++) push_exp(b2b_a[k], b2b_b[k]);
        @(posedge clk);
        #1;
        check("b2b_accept0", 32'(busy_v[0]), 32'd1);
        for (int k = 0; k < 4; k++) begin
            wait_result("b2b");
            if (k < 3) begin
                a_drv = b2b_a[k+1];
                b_drv = b2b_b[k+1];
            end else begin
                in_valid_v[0] = 1'b0;
            end
            @(posedge clk);
            #1;
            check("b2b_idle", 32'(in_ready_v[0]), 32'd1);
            if (k < 3) begin
                @(posedge clk);
                #1;
                check("b2b_accept", 32'(busy_v[0]), 32'd1);
            end
        end
        check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
